// File: rtl/ddr3_mcb_pkg.sv
// ddr3_mcb_pkg: shared MCB widths, beat-count derivation and write FSM encoding
package ddr3_mcb_pkg;
  localparam int MCB_D_W = 64;
  localparam int MCB_BE_W = MCB_D_W / 8;
  typedef enum logic {WR_IDLE = 1'b0, WR_LOADED = 1'b1} wr_state_t;
  function automatic int beats_of(input int axi_dw, input int mcb_dw);
    return axi_dw / mcb_dw;
  endfunction
  function automatic int cnt_w_of(input int axi_dw, input int mcb_dw);
    return $clog2(axi_dw / mcb_dw);
  endfunction
endpackage

// File: rtl/ddr3_data_path_gen_if.sv
// ddr3_data_path_gen_if: AXI-side and MCB-side data signals of the DDR3 data path
interface ddr3_data_path_gen_if #(
  parameter int AXI_DW = 256,
  parameter int MCB_D_W = ddr3_mcb_pkg::MCB_D_W
);
  logic ddr3_mcb_rdat_vld;
  logic [MCB_D_W-1:0] ddr3_mcb_rdat;
  logic [AXI_DW-1:0] read_data;
  logic data_ready;
  logic data_ready_clear;
  logic rd_overrun;
  logic write_load;
  logic [AXI_DW-1:0] write_data;
  logic [AXI_DW/8-1:0] write_wstrb;
  logic write_busy;
  logic ddr3_mcb_wdat_req;
  logic [MCB_D_W-1:0] ddr3_mcb_wdat;
  logic [MCB_D_W/8-1:0] ddr3_mcb_wbe;
  logic write_done;
  logic wr_underrun;
  modport slave (
    input ddr3_mcb_rdat_vld, ddr3_mcb_rdat, data_ready_clear, write_load, write_data, write_wstrb, ddr3_mcb_wdat_req,
    output read_data, data_ready, rd_overrun, write_busy, ddr3_mcb_wdat, ddr3_mcb_wbe, write_done, wr_underrun
  );
  modport master (
    output ddr3_mcb_rdat_vld, ddr3_mcb_rdat, data_ready_clear, write_load, write_data, write_wstrb, ddr3_mcb_wdat_req,
    input read_data, data_ready, rd_overrun, write_busy, ddr3_mcb_wdat, ddr3_mcb_wbe, write_done, wr_underrun
  );
endinterface

// File: rtl/ddr3_wr_serializer.sv
// ddr3_wr_serializer: buffers one AXI write word and issues it as MCB beats on request
module ddr3_wr_serializer import ddr3_mcb_pkg::*; #(
  parameter int AXI_DW = 256,
  parameter int SLICE_W = 64
) (
  input logic clk,
  input logic rst,
  input logic write_load,
  input logic [AXI_DW-1:0] write_data,
  input logic [AXI_DW/8-1:0] write_wstrb,
  output logic write_busy,
  input logic wdat_req,
  output logic [SLICE_W-1:0] wdat,
  output logic [SLICE_W/8-1:0] wbe,
  output logic write_done,
  output logic wr_underrun
);
  localparam int BEATS = beats_of(AXI_DW, SLICE_W);
  localparam int CNT_W = cnt_w_of(AXI_DW, SLICE_W);
  localparam int BE_W = SLICE_W / 8;
  wr_state_t state, nxt;
  logic [AXI_DW-1:0] data_buf;
  logic [AXI_DW/8-1:0] stb_buf;
  logic [CNT_W-1:0] wr_cnt;
  logic last, take, cap;
  always_ff @(posedge clk) state <= rst ? WR_IDLE : nxt;
  always_comb nxt = state == WR_IDLE ? (write_load ? WR_LOADED : WR_IDLE) : (wdat_req && last && !write_load ? WR_IDLE : WR_LOADED);
  always_comb begin
    last = wr_cnt == CNT_W'(BEATS - 1);
    write_busy = state == WR_LOADED;
    take = write_busy && wdat_req;
    cap = write_load && (!write_busy || (take && last));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      data_buf <= '0;
      stb_buf <= '0;
      wr_cnt <= '0;
      wdat <= '0;
      wbe <= '0;
      write_done <= 1'b0;
      wr_underrun <= 1'b0;
    end else begin
      write_done <= take && last;
      wr_underrun <= !write_busy && wdat_req;
      if (wdat_req) begin
        wdat <= take ? data_buf[wr_cnt*SLICE_W +: SLICE_W] : '0;
        wbe <= take ? stb_buf[wr_cnt*BE_W +: BE_W] : '0;
      end
      if (cap) begin
        data_buf <= write_data;
        stb_buf <= write_wstrb;
        wr_cnt <= '0;
      end else if (take) wr_cnt <= wr_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/ddr3_data_path_gen.sv
// ddr3_data_path_gen: gathers MCB read beats into AXI words and serialises AXI write words onto the MCB
module ddr3_data_path_gen #(
  parameter int AXI_DW = 256,
  parameter int MCB_D_W = ddr3_mcb_pkg::MCB_D_W
) (
  input logic ddr3_mcb_clk,
  input logic ddr3_mcb_rst,
  ddr3_data_path_gen_if.slave bus
);
  localparam int BEATS = ddr3_mcb_pkg::beats_of(AXI_DW, MCB_D_W);
  localparam int CNT_W = ddr3_mcb_pkg::cnt_w_of(AXI_DW, MCB_D_W);
  logic [CNT_W-1:0] rd_cnt;
  logic [AXI_DW-1:0] read_data;
  logic data_ready, rd_overrun, rd_take;
  always_comb rd_take = bus.ddr3_mcb_rdat_vld && (!data_ready || bus.data_ready_clear);
  always_ff @(posedge ddr3_mcb_clk) begin
    if (ddr3_mcb_rst) begin
      rd_cnt <= '0;
      read_data <= '0;
      data_ready <= 1'b0;
      rd_overrun <= 1'b0;
    end else begin
      rd_overrun <= bus.ddr3_mcb_rdat_vld && data_ready && !bus.data_ready_clear;
      data_ready <= (rd_take && rd_cnt == CNT_W'(BEATS - 1)) || (data_ready && !bus.data_ready_clear);
      if (rd_take) begin
        read_data[rd_cnt*MCB_D_W +: MCB_D_W] <= bus.ddr3_mcb_rdat;
        rd_cnt <= rd_cnt + 1'b1;
      end
    end
  end
  assign bus.read_data = read_data;
  assign bus.data_ready = data_ready;
  assign bus.rd_overrun = rd_overrun;
  ddr3_wr_serializer #(.AXI_DW(AXI_DW), .SLICE_W(MCB_D_W)) u_wr (
    .clk(ddr3_mcb_clk),
    .rst(ddr3_mcb_rst),
    .write_load(bus.write_load),
    .write_data(bus.write_data),
    .write_wstrb(bus.write_wstrb),
    .write_busy(bus.write_busy),
    .wdat_req(bus.ddr3_mcb_wdat_req),
    .wdat(bus.ddr3_mcb_wdat),
    .wbe(bus.ddr3_mcb_wbe),
    .write_done(bus.write_done),
    .wr_underrun(bus.wr_underrun)
  );
endmodule

// File: tb/tb_ddr3_data_path_gen.sv
// tb_ddr3_data_path_gen: scoreboard bench for ddr3_data_path_gen against a queue-based reference model
module tb_ddr3_data_path_gen;
  localparam int AXI_DW = 256;
  localparam int MCB_D_W = 64;
  localparam int BEATS = AXI_DW / MCB_D_W;
  localparam int BE_W = MCB_D_W / 8;
  typedef struct packed {
    logic dr;
    logic ovr;
    logic [AXI_DW-1:0] rd;
    logic busy;
    logic [MCB_D_W-1:0] wdat;
    logic [BE_W-1:0] wbe;
    logic done;
    logic und;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  ddr3_data_path_gen_if #(.AXI_DW(AXI_DW), .MCB_D_W(MCB_D_W)) bus();
  ddr3_data_path_gen #(.AXI_DW(AXI_DW), .MCB_D_W(MCB_D_W)) dut (
    .ddr3_mcb_clk(clk),
    .ddr3_mcb_rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  exp_t exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  logic d_rst, d_vld, d_clr, d_ld, d_req;
  logic [MCB_D_W-1:0] d_rdat;
  logic [AXI_DW-1:0] d_wd;
  logic [AXI_DW/8-1:0] d_ws;
  logic [MCB_D_W-1:0] m_slot [BEATS];
  int m_cnt;
  bit m_dr;
  logic [BE_W+MCB_D_W-1:0] m_wq[$];
  logic [MCB_D_W-1:0] m_wdat;
  logic [BE_W-1:0] m_wbe;
  task automatic chk(input string name, input logic [AXI_DW-1:0] got, input logic [AXI_DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
    end
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("data_ready", bus.data_ready, e.dr);
      chk("rd_overrun", bus.rd_overrun, e.ovr);
      chk("read_data", bus.read_data, e.rd);
      chk("write_busy", bus.write_busy, e.busy);
      chk("wdat", bus.ddr3_mcb_wdat, e.wdat);
      chk("wbe", bus.ddr3_mcb_wbe, e.wbe);
      chk("write_done", bus.write_done, e.done);
      chk("wr_underrun", bus.wr_underrun, e.und);
    end
  end
  task automatic model_step();
    exp_t e;
    bit was_empty;
    e = '0;
    if (d_rst) begin
      foreach (m_slot[k]) m_slot[k] = '0;
      m_cnt = 0;
      m_dr = 0;
      m_wq.delete();
      m_wdat = '0;
      m_wbe = '0;
    end else begin
      e.ovr = d_vld && m_dr && !d_clr;
      if (d_vld && (!m_dr || d_clr)) begin
        m_slot[m_cnt] = d_rdat;
        m_cnt = (m_cnt + 1) % BEATS;
        m_dr = (m_cnt == 0);
      end else if (d_clr) m_dr = 0;
      was_empty = m_wq.size() == 0;
      if (d_req) begin
        if (was_empty) begin
          e.und = 1'b1;
          m_wdat = '0;
          m_wbe = '0;
        end else begin
          {m_wbe, m_wdat} = m_wq.pop_front();
          e.done = m_wq.size() == 0;
        end
      end
      if (d_ld && m_wq.size() == 0)
        for (int k = 0; k < BEATS; k++) m_wq.push_back({d_ws[k*BE_W +: BE_W], d_wd[k*MCB_D_W +: MCB_D_W]});
    end
    for (int k = 0; k < BEATS; k++) e.rd[k*MCB_D_W +: MCB_D_W] = m_slot[k];
    e.dr = m_dr;
    e.busy = m_wq.size() != 0;
    e.wdat = m_wdat;
    e.wbe = m_wbe;
    exp_q.push_back(e);
  endtask
  task automatic clr_drv();
    d_rst = 0;
    d_vld = 0;
    d_clr = 0;
    d_ld = 0;
    d_req = 0;
    d_rdat = '0;
  endtask
  task automatic tick();
    rst = d_rst;
    bus.ddr3_mcb_rdat_vld = d_vld;
    bus.ddr3_mcb_rdat = d_rdat;
    bus.data_ready_clear = d_clr;
    bus.write_load = d_ld;
    bus.write_data = d_wd;
    bus.write_wstrb = d_ws;
    bus.ddr3_mcb_wdat_req = d_req;
    model_step();
    @(posedge clk);
    #1;
    clr_drv();
  endtask
  task automatic rnd_word();
    for (int k = 0; k < AXI_DW / 32; k++) d_wd[k*32 +: 32] = $urandom;
  endtask
  task automatic beat(input int i);
    logic [7:0] b;
    b = 8'((i + 1) * 17);
    d_vld = 1;
    d_rdat = {8{b}};
  endtask
  initial begin
    d_wd = '0;
    d_ws = '0;
    clr_drv();
    d_rst = 1;
    tick();
    d_rst = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      beat(i);
      tick();
    end
    tick();
    beat(4);
    tick();
    beat(5);
    d_clr = 1;
    tick();
    tick();
    rnd_word();
    d_ws = 32'hF00F_FF01;
    d_ld = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      d_req = 1;
      tick();
    end
    tick();
    rnd_word();
    d_ld = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      d_req = 1;
      if (i == 3) begin
        rnd_word();
        d_ws = 32'h1234_5678;
        d_ld = 1;
      end
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      d_req = 1;
      tick();
    end
    tick();
    d_req = 1;
    tick();
    tick();
    d_clr = 1;
    tick();
    rnd_word();
    d_ws = $urandom;
    d_ld = 1;
    tick();
    for (int i = 0; i < 2; i++) begin
      beat(i + 6);
      d_req = 1;
      tick();
    end
    d_rst = 1;
    tick();
    rnd_word();
    d_ld = 1;
    tick();
    for (int i = 0; i < 4; i++) begin
      beat(i + 8);
      d_req = 1;
      tick();
    end
    repeat (2) tick();
    for (int n = 0; n < 3000; n++) begin
      d_rst = ($urandom % 400) == 0;
      d_vld = $urandom_range(0, 1);
      d_rdat = {$urandom, $urandom};
      d_clr = ($urandom % 4) == 0;
      d_ld = ($urandom % 3) == 0;
      d_req = ($urandom % 3) != 0;
      if (d_ld) begin
        rnd_word();
        d_ws = $urandom;
      end
      tick();
    end
    @(negedge clk);
    #1;
    chk("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ddr3_data_path_gen.md
Name: ddr3_data_path_gen

Overview:
- Parametrised successor to the DDR3 MCB data path. Gathers MCB read beats into one AXI-width word, and serialises one buffered AXI write word (with strobes) onto the MCB write bus.
- Generalised over the AXI/MCB width ratio. Read and write sides use independent counters.
- Adds an explicit write-load handshake, write-done, read-overrun and write-underrun indications.
- Sits between the AXI slave front-end and the DDR3 MCB, in the ddr3_mcb_clk domain.

Parameters:
- AXI_DW, 256, AXI data width. Must be a multiple of MCB_D_W.
- MCB_D_W, 64, MCB data width. Must be a multiple of 8.
- MCB_BE_W, MCB_D_W/8, MCB byte-enable width (derived).
- BEATS, AXI_DW/MCB_D_W, MCB beats per AXI word (derived). Must be a power of 2 and ≥2.
- CNT_W, clog2(BEATS), width of the beat counters (derived).

Ports:
- ddr3_mcb_clk  in  1  sole clock; all logic on the rising edge.
- ddr3_mcb_rst  in  1  synchronous, active-high reset.
- ddr3_mcb_rdat_vld  in  1  MCB read beat valid.
- ddr3_mcb_rdat  in  MCB_D_W  MCB read beat.
- read_data  out  AXI_DW  assembled read word.
- data_ready  out  1  read word complete, held until cleared.
- data_ready_clear  in  1  consumer has taken read_data.
- rd_overrun  out  1  one-cycle pulse: beat dropped while data_ready=1.
- write_load  in  1  capture write_data/write_wstrb.
- write_data  in  AXI_DW  AXI write word.
- write_wstrb  in  AXI_DW/8  AXI byte strobes.
- write_busy  out  1  buffer holds unsent beats.
- ddr3_mcb_wdat_req  in  1  MCB requests the next write beat.
- ddr3_mcb_wdat  out  MCB_D_W  write beat.
- ddr3_mcb_wbe  out  MCB_BE_W  byte enables (1 = write byte).
- write_done  out  1  one-cycle pulse: last beat issued.
- wr_underrun  out  1  one-cycle pulse: request with no data.

Behaviour:
- Reset: every output and internal register goes to 0 (counters, buffers, read_data, flags, pulses). Asserting reset mid-burst abandons the partial word; no done or ready pulse is produced.
- Read counter rd_cnt: range 0..BEATS-1, wraps to 0 after the last beat. Beat k maps to read_data[k*MCB_D_W +: MCB_D_W], with beat 0 in the LSBs.
- Read beat acceptance: a beat is accepted when vld=1 and (data_ready=0 or data_ready_clear=1).
  - The slice is written at the edge the beat is accepted, and rd_cnt increments.
  - On the last beat (rd_cnt=BEATS-1), data_ready=1 at the same edge, so it is visible the cycle after the final beat.
- Read overrun: vld=1 while data_ready=1 and clear=0 drops the beat. read_data and rd_cnt hold, and rd_overrun pulses for 1 cycle.
- Read clear: data_ready_clear with data_ready=1 drops data_ready next edge. If vld is also 1 that cycle, the beat is accepted into the slot at rd_cnt (normally 0); clear wins over hold. data_ready_clear with data_ready=0 has no effect.
- Write FSM has two states, IDLE and LOADED; write_busy=1 exactly in LOADED.
  - IDLE, write_load=1: capture write_data/write_wstrb, set wr_cnt=0, go to LOADED.
  - LOADED, wdat_req=1: on the next edge, ddr3_mcb_wdat and ddr3_mcb_wbe take slice wr_cnt of the data and strobe buffers (1-cycle registered latency), and wr_cnt increments.
  - On the final request (wr_cnt=BEATS-1): write_done pulses and the FSM returns to IDLE, unless write_load=1 in that same cycle. In that case the new word is captured after the old last slice is taken, wr_cnt=0, the FSM stays in LOADED and write_done still pulses (back-to-back).
- write_load in LOADED, other than on the final-request cycle, is ignored. The front-end must wait for write_busy=0.
- IDLE with wdat_req=1: wdat and wbe are driven 0 and wr_underrun pulses. This includes a simultaneous write_load; the load is still captured.
- With no wdat_req, wdat and wbe hold their values.
- Read and write sides are fully independent; simultaneous activity on both is legal.

Decomposition:
- Package ddr3_mcb_pkg holds MCB_D_W, MCB_BE_W, the BEATS/CNT_W derivation function and the write FSM state encoding. It is shared with the MCB command path.
- One sub-module, ddr3_wr_serializer: the write buffer, wr_cnt, FSM, write_done and wr_underrun.
- The read gather stays in the top level.

Test Plan (AXI_DW=256, MCB_D_W=64):
- Read gather: 4 vld beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 → data_ready=1 the cycle after beat 4; read_data = {0x44..,0x33..,0x22..,0x11..}.
- Read overrun and clear: fifth beat 0x55.. while data_ready=1 → rd_overrun pulses 1 cycle, read_data unchanged. Then clear together with beat 0x66.. → data_ready=0, read_data[63:0]=0x66.., rd_cnt=1.
- Write serialise: load data={D3,D2,D1,D0}, wstrb=0xF0_0F_FF_01, then 4 reqs → wdat D0..D3 with wbe 0x01, 0xFF, 0x0F, 0xF0 on successive cycles, 1-cycle latency; write_done on the 4th; write_busy falls.
- Back-to-back: new load on the 4th req cycle → write_busy stays 1, write_done pulses, the next req yields the new word's slice 0.
- Underrun: req in IDLE → wdat=0, wbe=0, wr_underrun pulses once.
- Reset mid-burst: sync reset after 2 of 4 reads and 2 of 4 writes → all outputs 0. A following clean 4-beat read and write complete normally with no spurious data_ready or write_done.
